// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: walks a stored frame bottom-up, two pixels per read beat,
// with start-up delay, inter-line gaps, one-cycle write alignment and a done pulse.
module frame_seq_ctrl #(
   parameter int WIDTH          = 768,
   parameter int HEIGHT         = 512,
   parameter int START_UP_DELAY = 100,
   parameter int HSYNC_DELAY    = 160,
   parameter int ADDR_W         = 19
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              start,
   input  logic              hold,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              data_write,
   output logic              vsync,
   output logic              hsync,
   output logic              busy,
   output logic              ctrl_done
);

   localparam int DLY_MAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
   localparam int DLY_W   = $clog2(DLY_MAX + 1);
   localparam int COL_W   = $clog2(WIDTH + 1);
   localparam int ROW_W   = $clog2(HEIGHT + 1);

   localparam logic [DLY_W-1:0]  START_DLY  = DLY_W'(START_UP_DELAY);
   localparam logic [DLY_W-1:0]  GAP_DLY    = DLY_W'(HSYNC_DELAY);
   localparam logic [DLY_W-1:0]  DLY_ONE    = DLY_W'(1);
   localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(WIDTH - 2);
   localparam logic [COL_W-1:0]  COL_STEP   = COL_W'(2);
   localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(HEIGHT - 1);
   localparam logic [ROW_W-1:0]  ROW_ONE    = ROW_W'(1);
   localparam logic [ADDR_W-1:0] A_WIDTH    = ADDR_W'(WIDTH);
   localparam logic [ADDR_W-1:0] A_ROW_LAST = ADDR_W'(HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ACTIVE, S_HGAP, S_DRAIN, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DLY_W-1:0]  delay_q, delay_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ADDR_W-1:0] addr_q;
   logic              data_write_q;
   logic [ADDR_W-1:0] pix_addr;

   // Row 0 of the walk is the bottom line of the stored frame.
   assign pix_addr   = (A_ROW_LAST - ADDR_W'(row_q)) * A_WIDTH + ADDR_W'(col_q);
   assign rd_addr    = rd_en ? pix_addr : addr_q;
   assign data_write = data_write_q;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q      <= S_IDLE;
         delay_q      <= '0;
         row_q        <= '0;
         col_q        <= '0;
         addr_q       <= '0;
         data_write_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         delay_q      <= delay_d;
         row_q        <= row_d;
         col_q        <= col_d;
         addr_q       <= rd_addr;
         data_write_q <= rd_en;
      end
   end

   always_comb begin
      state_d   = state_q;
      delay_d   = delay_q;
      row_d     = row_q;
      col_d     = col_q;
      rd_en     = 1'b0;
      vsync     = 1'b0;
      hsync     = 1'b0;
      busy      = 1'b0;
      ctrl_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_START;
               delay_d = START_DLY;
            end
         end
         S_START: begin
            busy  = 1'b1;
            vsync = (delay_q == START_DLY);
            if (delay_q == DLY_ONE) begin
               state_d = S_ACTIVE;
               row_d   = '0;
               col_d   = '0;
            end else begin
               delay_d = delay_q - DLY_ONE;
            end
         end
         S_ACTIVE: begin
            busy = 1'b1;
            if (!hold) begin
               rd_en = 1'b1;
               if (col_q == COL_LAST) begin
                  if (row_q == ROW_LAST) begin
                     state_d = S_DRAIN;
                  end else begin
                     state_d = S_HGAP;
                     delay_d = GAP_DLY;
                     col_d   = '0;
                     row_d   = row_q + ROW_ONE;
                  end
               end else begin
                  col_d = col_q + COL_STEP;
               end
            end
         end
         S_HGAP: begin
            busy  = 1'b1;
            hsync = 1'b1;
            if (delay_q == DLY_ONE) begin
               state_d = S_ACTIVE;
            end else begin
               delay_d = delay_q - DLY_ONE;
            end
         end
         S_DRAIN: begin
            busy    = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            ctrl_done = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Bench for frame_seq_ctrl: per-cycle vector tables for an 8x4 frame plus a
// hand-written sequence for the 2x1 degenerate frame.
module tb_frame_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, hold;
   logic       rd_en, data_write, vsync, hsync, busy, ctrl_done;
   logic [4:0] rd_addr;

   logic       d_rst, d_start, d_hold;
   logic       d_rd_en, d_data_write, d_vsync, d_hsync, d_busy, d_ctrl_done;
   logic [0:0] d_rd_addr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   frame_seq_ctrl #(
      .WIDTH(8), .HEIGHT(4), .START_UP_DELAY(3), .HSYNC_DELAY(2), .ADDR_W(5)
   ) dut (
      .HCLK(clk), .HRESET(rst), .start(start), .hold(hold),
      .rd_en(rd_en), .rd_addr(rd_addr), .data_write(data_write),
      .vsync(vsync), .hsync(hsync), .busy(busy), .ctrl_done(ctrl_done)
   );

   frame_seq_ctrl #(
      .WIDTH(2), .HEIGHT(1), .START_UP_DELAY(1), .HSYNC_DELAY(1), .ADDR_W(1)
   ) dut_min (
      .HCLK(clk), .HRESET(d_rst), .start(d_start), .hold(d_hold),
      .rd_en(d_rd_en), .rd_addr(d_rd_addr), .data_write(d_data_write),
      .vsync(d_vsync), .hsync(d_hsync), .busy(d_busy), .ctrl_done(d_ctrl_done)
   );

   typedef struct {
      logic       start, hold, rst;
      logic       rd_en;
      logic [4:0] addr;
      logic       dw, vs, hs, busy, done;
   } vec_t;

   vec_t tbl [0:63];

   function automatic void clear_tbl();
      for (int i = 0; i < 64; i++) tbl[i] = '{default: '0};
   endfunction

   function automatic void set_rd(int c, int a);
      tbl[c].rd_en  = 1'b1;
      tbl[c].addr   = 5'(a);
      tbl[c + 1].dw = 1'b1;
   endfunction

   // 8x4 frame started at cycle s; ex stall cycles inserted right after the first read.
   function automatic void build_frame(int s, int ex);
      tbl[s + 1].vs = 1'b1;
      for (int c = s + 1; c <= s + 26 + ex; c++) tbl[c].busy = 1'b1;
      for (int l = 0; l < 4; l++)
         for (int i = 0; i < 4; i++)
            set_rd(s + 4 + 6 * l + i + ((l == 0 && i == 0) ? 0 : ex), (3 - l) * 8 + 2 * i);
      for (int g = 0; g < 3; g++) begin
         tbl[s + 8 + 6 * g + ex].hs = 1'b1;
         tbl[s + 9 + 6 * g + ex].hs = 1'b1;
      end
      tbl[s + 27 + ex].done = 1'b1;
   endfunction

   // rd_addr keeps its last value between reads and is 0 after a reset.
   function automatic void hold_addr(int n);
      for (int c = 0; c < n; c++)
         if (!tbl[c].rd_en)
            tbl[c].addr = (c == 0 || tbl[c - 1].rst) ? 5'd0 : tbl[c - 1].addr;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0; hold = 1'b0;
      d_rst = 1'b1; d_start = 1'b0; d_hold = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      d_rst = 1'b0;
   endtask

   task automatic run_tbl(input string name, input int n, input int exp_rd, input int exp_dw);
      logic [10:0] got, exp;
      int rd_cnt, dw_cnt;
      rd_cnt = 0;
      dw_cnt = 0;
      do_reset();
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         start = tbl[c].start;
         hold  = tbl[c].hold;
         rst   = tbl[c].rst;
         @(negedge clk);
         got = {rd_en, rd_addr, data_write, vsync, hsync, busy, ctrl_done};
         exp = {tbl[c].rd_en, tbl[c].addr, tbl[c].dw, tbl[c].vs, tbl[c].hs,
                tbl[c].busy, tbl[c].done};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d got rd_en/addr/dw/vs/hs/busy/done=%b required=%b",
                     name, c, got, exp);
         end
         if (rd_en === 1'b1) rd_cnt++;
         if (data_write === 1'b1) dw_cnt++;
      end
      checks++;
      if (rd_cnt != exp_rd) begin
         failures++;
         $display("FAIL %s rd_en_count got=%0d required=%0d", name, rd_cnt, exp_rd);
      end
      checks++;
      if (dw_cnt != exp_dw) begin
         failures++;
         $display("FAIL %s data_write_count got=%0d required=%0d", name, dw_cnt, exp_dw);
      end
      @(posedge clk); #1;
      start = 1'b0; hold = 1'b0; rst = 1'b0;
   endtask

   initial begin
      logic [6:0] dexp [0:5];
      logic [6:0] dgot;

      // Reset state of both instances.
      do_reset();
      @(negedge clk);
      checks++;
      if ({rd_en, rd_addr, data_write, vsync, hsync, busy, ctrl_done} !== 11'd0) begin
         failures++;
         $display("FAIL reset_state got=%b required=0",
                  {rd_en, rd_addr, data_write, vsync, hsync, busy, ctrl_done});
      end
      checks++;
      if ({d_rd_en, d_rd_addr, d_data_write, d_vsync, d_hsync, d_busy, d_ctrl_done} !== 7'd0) begin
         failures++;
         $display("FAIL reset_state_min got=%b required=0",
                  {d_rd_en, d_rd_addr, d_data_write, d_vsync, d_hsync, d_busy, d_ctrl_done});
      end

      // Basic frame.
      clear_tbl();
      tbl[0].start = 1'b1;
      build_frame(0, 0);
      hold_addr(30);
      run_tbl("basic", 30, 16, 16);

      // Hold in ACTIVE for cycles 5-6.
      clear_tbl();
      tbl[0].start = 1'b1;
      tbl[5].hold  = 1'b1;
      tbl[6].hold  = 1'b1;
      build_frame(0, 2);
      hold_addr(32);
      run_tbl("hold_active", 32, 16, 16);

      // Hold throughout START and every HGAP: no effect on timing.
      clear_tbl();
      tbl[0].start = 1'b1;
      for (int c = 1; c <= 3; c++) tbl[c].hold = 1'b1;
      for (int g = 0; g < 3; g++) begin
         tbl[8 + 6 * g].hold = 1'b1;
         tbl[9 + 6 * g].hold = 1'b1;
      end
      build_frame(0, 0);
      hold_addr(30);
      run_tbl("hold_gaps", 30, 16, 16);

      // Start pulses while busy and in DONE are ignored; the one in IDLE starts frame two.
      clear_tbl();
      tbl[0].start  = 1'b1;
      tbl[10].start = 1'b1;
      tbl[27].start = 1'b1;
      tbl[28].start = 1'b1;
      build_frame(0, 0);
      build_frame(28, 0);
      hold_addr(58);
      run_tbl("start_busy", 58, 32, 32);

      // Reset in cycle 12 aborts the frame; a later start runs a full frame.
      clear_tbl();
      build_frame(0, 0);
      for (int c = 13; c < 64; c++) tbl[c] = '{default: '0};
      tbl[0].start  = 1'b1;
      tbl[12].rst   = 1'b1;
      tbl[15].start = 1'b1;
      build_frame(15, 0);
      hold_addr(45);
      run_tbl("reset_mid", 45, 23, 22);

      // Degenerate 2x1 frame: {rd_en, addr, dw, vsync, hsync, busy, done}.
      dexp[0] = 7'b0_0_0_0_0_0_0;
      dexp[1] = 7'b0_0_0_1_0_1_0;
      dexp[2] = 7'b1_0_0_0_0_1_0;
      dexp[3] = 7'b0_0_1_0_0_1_0;
      dexp[4] = 7'b0_0_0_0_0_0_1;
      dexp[5] = 7'b0_0_0_0_0_0_0;
      do_reset();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         d_start = (c == 0);
         @(negedge clk);
         dgot = {d_rd_en, d_rd_addr, d_data_write, d_vsync, d_hsync, d_busy, d_ctrl_done};
         checks++;
         if (dgot !== dexp[c]) begin
            failures++;
            $display("FAIL degenerate cycle %0d got=%b required=%b", c, dgot, dexp[c]);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
